// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmit encoder.
//   - PID nibbles for the handshake/data packets the TX FSM emits
//   - packet_select encodings
//   - default SYNC byte
//   - line-state and encoder-state enums
//   - small NRZI / PID helpers
package usb_tx_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [1:0] {
    SEL_SYNC = 2'd0,
    SEL_PID  = 2'd1,
    SEL_DATA = 2'd2,
    SEL_ZERO = 2'd3
  } pkt_sel_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

  typedef enum logic [1:0] {
    LINE_J,
    LINE_K,
    LINE_SE0
  } line_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } enc_state_e;

  // NRZI: a 0 toggles J<->K, a 1 holds the current level.
  function automatic line_e nrzi_next(input line_e cur, input logic bit_val);
    if (bit_val) return cur;
    return (cur == LINE_J) ? LINE_K : LINE_J;
  endfunction

  // PID byte carries the check nibble (complement) in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_encoder_timer.sv
// tx_bit_timer: bit-time rollover counter.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : counter advances only while high
//   clear       : synchronous clear back to 0
//   bit_strobe  : last clock of a bit time (count = CLKS_PER_BIT-1, enabled)
//   pre_strobe  : clock before that (count = CLKS_PER_BIT-2, enabled), used
//                 to line up registered pulses with the bit boundary
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_strobe,
  output logic pre_strobe
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_strobe = enable && (count == LAST);
  assign pre_strobe = enable && (count == PRE);

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: bit-level USB full-speed transmit datapath.
// Serialises SYNC / PID / data bytes LSB-first with bit stuffing and NRZI,
// then sends EOP (2 bit times SE0 + 1 bit time J).
//   clk, rst        : clock, synchronous active-high reset
//   manual_load     : load byte chosen by packet_select (IDLE only)
//   initiate        : start serialising the loaded byte (IDLE only)
//   packet_select   : 0 SYNC, 1 PID, 2 tx_packet_data, 3 zero byte
//   tx_packet       : PID nibble
//   tx_packet_data  : show-ahead FIFO data byte
//   send_eop        : at the next byte end, send EOP instead of a new byte
//   enable_timer    : bit timer runs only while high (line freezes when low)
//   clear_timer     : abort, return to idle J
//   dplus_out/dminus_out : registered line drive
//   next_byte       : pulse in last clock of a byte's last bit (incl. stuff)
//   eop_done        : pulse in last clock of the EOP J bit
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       manual_load,
  input  logic       initiate,
  input  logic [1:0] packet_select,
  input  logic [3:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic       send_eop,
  input  logic       enable_timer,
  input  logic       clear_timer,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       next_byte,
  output logic       eop_done
);

  enc_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] ones_q, ones_d;
  logic       se0_cnt_q, se0_cnt_d;
  line_e      line_q, line_d;
  logic       next_byte_d, eop_done_d;

  logic       bit_strobe, pre_strobe;
  logic [7:0] sel_byte;
  logic       tx_bit, stuff_due, advance;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable_timer),
    .clear      (clear_timer || (state_q == ST_IDLE)),
    .bit_strobe (bit_strobe),
    .pre_strobe (pre_strobe)
  );

  always_comb begin
    unique case (pkt_sel_e'(packet_select))
      SEL_SYNC: sel_byte = SYNC_BYTE;
      SEL_PID:  sel_byte = pid_byte(tx_packet);
      SEL_DATA: sel_byte = tx_packet_data;
      default:  sel_byte = 8'h00;
    endcase
  end

  assign tx_bit    = shreg_q[0];
  // Sixth consecutive 1 is on the line now: a stuff bit must follow it.
  assign stuff_due = tx_bit && (ones_q == 3'd5);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    se0_cnt_d   = se0_cnt_q;
    line_d      = line_q;
    next_byte_d = 1'b0;
    eop_done_d  = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        line_d = LINE_J;
        if (initiate) begin
          state_d   = ST_SHIFT;
          bit_idx_d = 3'd0;
          ones_d    = 3'd0;
          line_d    = nrzi_next(LINE_J, shreg_q[0]);
        end else if (manual_load) begin
          shreg_d = sel_byte;
        end
      end

      ST_SHIFT: begin
        // Pulses are registered, so they are raised one clock ahead of the
        // boundary they mark.
        next_byte_d = pre_strobe && (bit_idx_q == 3'd7) && !stuff_due;
        if (bit_strobe) begin
          if (stuff_due) begin
            state_d = ST_STUFF;
            ones_d  = 3'd0;
            line_d  = nrzi_next(line_q, 1'b0);
          end else begin
            ones_d  = tx_bit ? ones_q + 3'd1 : 3'd0;
            advance = 1'b1;
          end
        end
      end

      ST_STUFF: begin
        next_byte_d = pre_strobe && (bit_idx_q == 3'd7);
        advance     = bit_strobe;
      end

      ST_EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_cnt_q) begin
            state_d   = ST_EOP_J;
            se0_cnt_d = 1'b0;
            line_d    = LINE_J;
          end else begin
            se0_cnt_d = 1'b1;
          end
        end
      end

      ST_EOP_J: begin
        eop_done_d = pre_strobe;
        if (bit_strobe) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Move on to the next data bit, the next byte, or EOP. The new byte's
    // first bit goes out straight after the boundary, with no gap.
    if (advance) begin
      state_d = ST_SHIFT;
      if (bit_idx_q != 3'd7) begin
        shreg_d   = shreg_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        line_d    = nrzi_next(line_q, shreg_q[1]);
      end else if (send_eop) begin
        state_d   = ST_EOP_SE0;
        ones_d    = 3'd0;
        se0_cnt_d = 1'b0;
        line_d    = LINE_SE0;
      end else begin
        shreg_d   = sel_byte;
        bit_idx_d = 3'd0;
        line_d    = nrzi_next(line_q, sel_byte[0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the shift register is a single byte of datapath state, not a
    // memory array, so it is cleared with everything else on reset/abort.
    if (rst || clear_timer) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      ones_q     <= 3'd0;
      se0_cnt_q  <= 1'b0;
      line_q     <= LINE_J;
      dplus_out  <= 1'b1;
      dminus_out <= 1'b0;
      next_byte  <= 1'b0;
      eop_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      se0_cnt_q  <= se0_cnt_d;
      line_q     <= line_d;
      dplus_out  <= (line_d == LINE_J);
      dminus_out <= (line_d == LINE_K);
      next_byte  <= next_byte_d;
      eop_done   <= eop_done_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder. A table of packets with hand-derived
// byte-end / EOP timings, plus randomized packets, each compared cycle by
// cycle against a flat bit-stream model built from the packet bytes.
module tb_usb_tx_encoder;
  import usb_tx_pkg::*;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst, manual_load, initiate, send_eop, enable_timer, clear_timer;
  logic [1:0] packet_select;
  logic [3:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic       dplus_out, dminus_out, next_byte, eop_done;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .manual_load    (manual_load),
    .initiate       (initiate),
    .packet_select  (packet_select),
    .tx_packet      (tx_packet),
    .tx_packet_data (tx_packet_data),
    .send_eop       (send_eop),
    .enable_timer   (enable_timer),
    .clear_timer    (clear_timer),
    .dplus_out      (dplus_out),
    .dminus_out     (dminus_out),
    .next_byte      (next_byte),
    .eop_done       (eop_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int               nbytes;
    logic [3:0][1:0]  sel;
    logic [3:0][3:0]  pid;
    logic [3:0][7:0]  data;
    int               freeze_at;   // first cycle of a 20-cycle enable_timer drop
    int               abort_at;    // cycle in which clear_timer / rst is raised
    bit               abort_rst;
    int               exp_last_nb; // -2 = not checked
    int               exp_eop;     // -1 = no eop_done expected
  } pkt_t;

  typedef struct packed {
    logic dp, dm, nb, ed;
  } obs_t;

  obs_t exp_q[$];
  pkt_t table_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [1:0] sel, input logic [3:0] pid,
                                         input logic [7:0] data);
    case (sel)
      2'd0:    return 8'h80;
      2'd1:    return {~pid, pid};
      2'd2:    return data;
      default: return 8'h00;
    endcase
  endfunction

  function automatic pkt_t mk(input int n, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [3:0] pid,
                              input logic [7:0] d1, input logic [7:0] d2, input int frz,
                              input int abt, input bit abt_rst, input int lnb, input int eop);
    pkt_t p;
    p.nbytes = n;
    p.sel = {2'd3, s2, s1, s0};
    p.pid = {pid, pid, pid, pid};
    p.data = {8'h00, d2, d1, 8'h00};
    p.freeze_at = frz;
    p.abort_at = abt;
    p.abort_rst = abt_rst;
    p.exp_last_nb = lnb;
    p.exp_eop = eop;
    return p;
  endfunction

  // Expected outputs, one entry per cycle starting the cycle after initiate.
  task automatic push_bit(input bit level_j);
    obs_t o;
    o = '{dp: level_j, dm: !level_j, nb: 1'b0, ed: 1'b0};
    repeat (CPB) exp_q.push_back(o);
  endtask

  task automatic build_model(input pkt_t p);
    bit     level_j = 1'b1;
    int     run = 0;
    logic [7:0] b;
    obs_t   o;
    exp_q.delete();
    for (int i = 0; i < p.nbytes; i++) begin
      b = byte_of(p.sel[i], p.pid[i], p.data[i]);
      for (int j = 0; j < 8; j++) begin
        if (!b[j]) level_j = !level_j;
        push_bit(level_j);
        run = b[j] ? run + 1 : 0;
        if (run == 6) begin
          level_j = !level_j;
          push_bit(level_j);
          run = 0;
        end
      end
      exp_q[exp_q.size()-1].nb = 1'b1;
    end
    o = '{dp: 1'b0, dm: 1'b0, nb: 1'b0, ed: 1'b0};
    repeat (2*CPB) exp_q.push_back(o);
    push_bit(1'b1);
    exp_q[exp_q.size()-1].ed = 1'b1;
    if (p.freeze_at >= 0) begin
      o = exp_q[p.freeze_at];
      repeat (20) exp_q.insert(p.freeze_at, o);
    end
    if (p.abort_at >= 0) begin
      while (exp_q.size() > p.abort_at + 1) void'(exp_q.pop_back());
    end
    o = '{dp: 1'b1, dm: 1'b0, nb: 1'b0, ed: 1'b0};
    repeat (6) exp_q.push_back(o);
  endtask

  task automatic drive_idle();
    manual_load = 0; initiate = 0; send_eop = 0; clear_timer = 0; rst = 0;
    enable_timer = 1; packet_select = 2'd0; tx_packet = 4'h0; tx_packet_data = 8'h00;
  endtask

  // Inputs for the byte that follows byte i are held for the whole of byte i.
  task automatic drive_next(input pkt_t p, input int i);
    if (i + 1 < p.nbytes) begin
      send_eop = 0;
      packet_select = p.sel[i+1];
      tx_packet = p.pid[i+1];
      tx_packet_data = p.data[i+1];
    end else begin
      send_eop = 1;
    end
  endtask

  task automatic run_packet(input pkt_t p, input int id);
    int   nb_idx = 0;
    int   last_nb = -1;
    int   eop_at = -1;
    obs_t got;
    build_model(p);
    @(posedge clk); #1;
    drive_idle();
    manual_load = 1;
    packet_select = p.sel[0]; tx_packet = p.pid[0]; tx_packet_data = p.data[0];
    @(posedge clk); #1;
    manual_load = 0;
    initiate = 1;
    drive_next(p, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      initiate = 0;
      if (p.abort_at >= 0 && k > p.abort_at) begin
        drive_idle();
      end else begin
        drive_next(p, nb_idx);
        enable_timer = !(p.freeze_at >= 0 && k >= p.freeze_at && k < p.freeze_at + 20);
        clear_timer = (k == p.abort_at) && !p.abort_rst;
        rst = (k == p.abort_at) && p.abort_rst;
      end
      @(negedge clk);
      got = '{dp: dplus_out, dm: dminus_out, nb: next_byte, ed: eop_done};
      check($sformatf("pkt%0d cyc%0d {dp,dm,nb,ed}", id, k), 32'(got), 32'(exp_q[k]));
      if (next_byte === 1'b1) last_nb = k;
      if (eop_done === 1'b1 && eop_at < 0) eop_at = k;
      if (exp_q[k].nb) nb_idx++;
    end
    drive_idle();
    if (p.exp_last_nb != -2) begin
      check($sformatf("pkt%0d last next_byte cycle", id), 32'(last_nb), 32'(p.exp_last_nb));
      check($sformatf("pkt%0d eop_done cycle", id), 32'(eop_at), 32'(p.exp_eop));
    end
  endtask

  initial begin
    pkt_t p;
    drive_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset line/pulses", {dplus_out, dminus_out, next_byte, eop_done}, 32'b1000);
    @(posedge clk); #1;
    rst = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle line/pulses", {dplus_out, dminus_out, next_byte, eop_done}, 32'b1000);

    // Cycle numbers are counted from T+1 (index 0), T = initiate cycle.
    table_q.push_back(mk(2, SEL_SYNC, SEL_PID, SEL_ZERO, PID_ACK, 8'h00, 8'h00,
                         -1, -1, 0, 127, 151));
    table_q.push_back(mk(3, SEL_SYNC, SEL_PID, SEL_DATA, PID_DATA0, 8'h00, 8'hFF,
                         -1, -1, 0, 199, 223));
    table_q.push_back(mk(3, SEL_SYNC, SEL_DATA, SEL_DATA, PID_ACK, 8'h00, 8'hFC,
                         -1, -1, 0, 199, 223));
    table_q.push_back(mk(3, SEL_SYNC, SEL_PID, SEL_ZERO, PID_NAK, 8'h00, 8'h00,
                         -1, -1, 0, 191, 215));
    table_q.push_back(mk(2, SEL_SYNC, SEL_DATA, SEL_ZERO, PID_ACK, 8'h5A, 8'h00,
                         100, -1, 0, 147, 171));
    table_q.push_back(mk(3, SEL_SYNC, SEL_DATA, SEL_DATA, PID_ACK, 8'hA5, 8'h3C,
                         -1, 100, 0, 63, -1));
    table_q.push_back(mk(2, SEL_SYNC, SEL_PID, SEL_ZERO, PID_NAK, 8'h00, 8'h00,
                         -1, -1, 0, 127, 151));
    table_q.push_back(mk(2, SEL_SYNC, SEL_PID, SEL_ZERO, PID_ACK, 8'h00, 8'h00,
                         -1, 134, 1, 127, -1));
    table_q.push_back(mk(2, SEL_SYNC, SEL_PID, SEL_ZERO, PID_DATA1, 8'h00, 8'h00,
                         -1, -1, 0, 127, 151));

    for (int t = 0; t < table_q.size(); t++) run_packet(table_q[t], t);

    for (int r = 0; r < 25; r++) begin
      p.nbytes = int'($urandom_range(2, 4));
      p.sel[0] = SEL_SYNC;
      for (int i = 1; i < 4; i++) begin
        p.sel[i] = 2'($urandom_range(0, 3));
        p.pid[i] = 4'($urandom);
        p.data[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      end
      p.pid[0] = 4'h0;
      p.data[0] = 8'h00;
      p.freeze_at = -1;
      p.abort_at = -1;
      p.abort_rst = 0;
      p.exp_last_nb = -2;
      p.exp_eop = -1;
      run_packet(p, 100 + r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
